// File: rtl/mc_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: opcodes, datapath
// select encodings and the state enumeration.
package mc_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADDR  = 4'd2,
        ST_MEMRD    = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWR    = 4'd5,
        ST_EXEC     = 4'd6,
        ST_RTYPE_WB = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_JUMP     = 4'd9,
        ST_ADDI_EX  = 4'd10,
        ST_ADDI_WB  = 4'd11,
        ST_TRAP     = 4'd15
    } state_e;

endpackage

// File: rtl/mc_control.sv
// Multi-cycle control FSM for the MIPS datapath. Moore outputs decoded from
// the current state; FETCH additionally gates IRWrite/PCWrite on mem_ready.
//
// state    | meaning
// ---------+---------------------------------------------------------
// FETCH    | read instruction at PC, PC+4 -> PC when memory is ready
// DECODE   | read registers, branch target -> ALUOut, dispatch on opcode
// MEMADDR  | rs + signext(imm) -> ALUOut for load/store
// MEMRD    | read data memory at ALUOut, wait for mem_ready
// MEMWB    | MDR -> rt
// MEMWR    | write data memory at ALUOut, wait for mem_ready
// EXEC     | R-type ALU operation on rs, rt
// RTYPE_WB | ALUOut -> rd
// BRANCH   | compare rs/rt, load branch target when equal
// JUMP     | load jump target into PC
// ADDI_EX  | rs + signext(imm)
// ADDI_WB  | ALUOut -> rt
// TRAP     | illegal opcode, parked until reset
module mc_control
    import mc_control_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;

    // Next-state selection, retire detection and sticky trap flag.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                unique case (opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADDR;
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI:      state_d = ST_ADDI_EX;
                    default:      state_d = ST_TRAP;
                endcase
            end
            ST_MEMADDR:  state_d = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:    if (mem_ready) state_d = ST_MEMWB;
            ST_MEMWB:    state_d = ST_FETCH;
            ST_MEMWR:    if (mem_ready) state_d = ST_FETCH;
            ST_EXEC:     state_d = ST_RTYPE_WB;
            ST_RTYPE_WB: state_d = ST_FETCH;
            ST_BRANCH:   state_d = ST_FETCH;
            ST_JUMP:     state_d = ST_FETCH;
            ST_ADDI_EX:  state_d = ST_ADDI_WB;
            ST_ADDI_WB:  state_d = ST_FETCH;
            ST_TRAP:     state_d = ST_TRAP;
            default:     state_d = ST_FETCH;
        endcase

        retire    = (state_d == ST_FETCH) && (state_q != ST_FETCH) && (state_q != ST_TRAP);
        count_d   = retire ? count_q + CNT_W'(1) : count_q;
        illegal_d = illegal_q | ((state_q == ST_DECODE) && (state_d == ST_TRAP));
    end

    // Datapath controls from the current state; reset forces everything low.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RT;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        if (!rst) begin
            unique case (state_q)
                ST_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                ST_DECODE:  ALUSrcB = SRCB_IMM_SH2;
                ST_MEMADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                ST_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                ST_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                ST_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                ST_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_FUNCT;
                end
                ST_RTYPE_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                ST_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALUOP_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                end
                ST_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_JUMP;
                end
                ST_ADDI_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                ST_ADDI_WB: RegWrite = 1'b1;
                default: ;
            endcase
        end
    end

    // State, sticky illegal flag and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    assign state       = state_q;
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control FSM that sequences the MIPS datapath (PC, instruction/data memory, register file, ALU) over several clocks per instruction instead of one. It decodes the opcode captured in the instruction register and drives every datapath mux select and write enable cycle by cycle. It also stalls on a memory-ready handshake, traps illegal opcodes, and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instruction[31:26] from instruction register
- mem_ready  in  1  memory completes current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero (beq)
- IorD  out  1  memory address: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  load instruction register
- MemtoReg  out  1  register write data: 0=ALUOut, 1=MDR
- RegDst  out  1  write reg: 0=rt, 1=rd
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0=PC, 1=rs
- ALUSrcB  out  2  00=rt, 01=const 4, 10=signext imm, 11=signext imm<<2
- ALUOp  out  2  00=add, 01=sub, 10=funct field
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- state  out  4  current FSM state (debug)
- illegal  out  1  sticky illegal-opcode flag
- instr_count  out  CNT_W  retired instructions

## Operation
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000; all others illegal.
- States and Moore outputs (unlisted enables = 0, unlisted selects = 0):
  - FETCH: MemRead, ALUSrcB=01, ALUOp=00. If mem_ready: IRWrite=1, PCWrite=1 -> DECODE. Otherwise hold in FETCH with IRWrite=0 and PCWrite=0.
  - DECODE: ALUSrcB=11, ALUOp=00 (branch target to ALUOut). Next state by opcode: LW/SW->MEMADDR, RTYPE->EXEC, BEQ->BRANCH, J->JUMP, ADDI->ADDI_EX, other->TRAP.
  - MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW->MEMRD, SW->MEMWR.
  - MEMRD: MemRead, IorD=1. On mem_ready -> MEMWB, else hold.
  - MEMWB: RegWrite, MemtoReg=1, RegDst=0 -> FETCH.
  - MEMWR: MemWrite, IorD=1. On mem_ready -> FETCH, else hold.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RTYPE_WB.
  - RTYPE_WB: RegWrite, RegDst=1, MemtoReg=0 -> FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01 -> FETCH.
  - JUMP: PCWrite, PCSource=10 -> FETCH.
  - ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDI_WB.
  - ADDI_WB: RegWrite, RegDst=0, MemtoReg=0 -> FETCH.
  - TRAP: all enables 0; illegal=1. Stays in TRAP until rst.
- Retire: instr_count increments by 1 on each cycle whose next state is FETCH, taken from a state other than FETCH and TRAP. The counter wraps modulo 2^CNT_W.
- illegal sets on the DECODE->TRAP transition. Only rst clears it.

## Timing
- Reset (rst high at a clk edge): state=FETCH, illegal=0, instr_count=0. While rst is high, all write/request enables (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite) are forced to 0, and selects are 0.
- rst mid-instruction: the next state is FETCH regardless of the current state or mem_ready. No partial register write occurs in the reset cycle.
- Outputs are combinational from state. In FETCH, IRWrite and PCWrite are additionally gated by mem_ready.
- CPI with mem_ready=1 every cycle: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. During the stall, outputs stay constant.
- mem_ready is ignored in all other states.
- opcode is sampled only in DECODE and MEMADDR. It must stay stable from IRWrite until FETCH is re-entered.

## Structure
- Shared package: opcode constants; ALUOp, ALUSrcB and PCSource encodings; a 4-bit state enum with FETCH=0, DECODE=1, MEMADDR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTYPE_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, TRAP=15.
- Single module with a next-state block, an output decode block, and a state/flag/counter register block. No sub-modules.

## Test plan
- Reset then LW, mem_ready=1: state sequence 0,1,2,3,4,0. RegWrite=1 with MemtoReg=1 in cycle 5 only. instr_count=1.
- SW with mem_ready low for 2 cycles in MEMWR: MemWrite held high for 3 cycles, IorD=1. Total 6 cycles. No RegWrite.
- RTYPE, then BEQ, then J back to back: 4+3+3=10 cycles. PCWriteCond=1 with ALUOp=01 only in BRANCH. PCSource=10 in JUMP. instr_count=3.
- FETCH with mem_ready=0 for 3 cycles: IRWrite=0 and PCWrite=0 throughout. Both go high on the first mem_ready=1 cycle.
- Opcode 111111: DECODE->TRAP, illegal=1, all enables 0 for 20 cycles, instr_count unchanged. rst then gives FETCH, illegal=0, instr_count=0.
- rst asserted in MEMRD: next state FETCH. No RegWrite pulse. instr_count=0.
